// File: rtl/sync_debounce_edge.sv
// Multi-channel pad conditioner. Each pin is synchronised, then debounced with a
// tick-gated stability counter; it emits a clean level plus registered rise/fall pulses.

module sync_debounce_edge_lane #(
    parameter int   STAGES    = 2,
    parameter int   DB_CYCLES = 4,
    parameter logic RST_BIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int             CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic [STAGES-1:0] sync;
    logic [CW-1:0]     cnt;
    logic              s;

    // Plain flop chain: nothing may sit between stages or metastability leaks through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= {STAGES{RST_BIT}};
        else     sync <= {sync[STAGES-2:0], in};
    end

    assign s = sync[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= RST_BIT;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (tick) begin
                // Acceptance on the last qualifying tick; the counter never reaches DB_CYCLES.
                if (cnt == CNT_MAX) begin
                    level <= s;
                    cnt   <= '0;
                    rise  <= s;
                    fall  <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module sync_debounce_edge #(
    parameter int               WIDTH     = 4,
    parameter int               STAGES    = 2,
    parameter int               DB_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             tick,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sync_debounce_edge_lane #(
            .STAGES    (STAGES),
            .DB_CYCLES (DB_CYCLES),
            .RST_BIT   (RST_VAL[i])
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .in    (in[i]),
            .tick  (tick),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign any_edge = |(rise | fall);
endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench: one instance with RST_VAL=0 for the main function, one with RST_VAL=0101
// for reset/release behaviour. Inputs change 1 time unit after posedge; samples taken there.

module tb_sync_debounce_edge;
    logic       clk = 1'b0;
    logic       rst, rst_r, tick;
    logic [3:0] in, in_r;
    logic [3:0] level, rise, fall, level_r, rise_r, fall_r;
    logic       any_edge, any_edge_r;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sync_debounce_edge #(.WIDTH(4), .STAGES(2), .DB_CYCLES(4), .RST_VAL(4'b0000)) dut (
        .clk(clk), .rst(rst), .in(in), .tick(tick),
        .level(level), .rise(rise), .fall(fall), .any_edge(any_edge)
    );

    sync_debounce_edge #(.WIDTH(4), .STAGES(2), .DB_CYCLES(4), .RST_VAL(4'b0101)) dut_r (
        .clk(clk), .rst(rst_r), .in(in_r), .tick(tick),
        .level(level_r), .rise(rise_r), .fall(fall_r), .any_edge(any_edge_r)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst_r = 1'b1; tick = 1'b1;
        in = 4'b1111; in_r = 4'b1010;

        // reset state, before any clock edge
        #2;
        chk("rst_level_r", level_r, 4'b0101);
        chk("rst_rise_r", rise_r, 4'b0000);
        chk("rst_fall_r", fall_r, 4'b0000);
        chk("rst_any_r", {3'b0, any_edge_r}, 4'b0000);
        chk("rst_level", level, 4'b0000);
        step(3);
        chk("rst_hold_level_r", level_r, 4'b0101);
        chk("rst_hold_rise_r", rise_r, 4'b0000);

        // release of dut_r with inputs opposite to RST_VAL
        rst_r = 1'b0;
        step(5);
        chk("rel_r_e5_level", level_r, 4'b0101);
        chk("rel_r_e5_rise", rise_r, 4'b0000);
        step(1);
        chk("rel_r_e6_level", level_r, 4'b1010);
        chk("rel_r_e6_rise", rise_r, 4'b1010);
        chk("rel_r_e6_fall", fall_r, 4'b0101);
        chk("rel_r_e6_any", {3'b0, any_edge_r}, 4'b0001);
        step(1);
        chk("rel_r_e7_level", level_r, 4'b1010);
        chk("rel_r_e7_rise", rise_r, 4'b0000);
        chk("rel_r_e7_fall", fall_r, 4'b0000);
        chk("rel_r_e7_any", {3'b0, any_edge_r}, 4'b0000);

        // reset mid-count: level reverts at once and the partial count is lost
        in_r = 4'b0101;
        step(4);
        rst_r = 1'b1;
        #1;
        chk("midcnt_revert", level_r, 4'b0101);
        in_r = 4'b1010;
        step(1);
        rst_r = 1'b0;
        step(5);
        chk("midcnt_e5_level", level_r, 4'b0101);
        step(1);
        chk("midcnt_e6_level", level_r, 4'b1010);
        chk("midcnt_e6_rise", rise_r, 4'b1010);

        // release of dut with in=1111, RST_VAL=0
        rst = 1'b0;
        step(5);
        chk("rel_e5_level", level, 4'b0000);
        chk("rel_e5_rise", rise, 4'b0000);
        chk("rel_e5_any", {3'b0, any_edge}, 4'b0000);
        step(1);
        chk("rel_e6_level", level, 4'b1111);
        chk("rel_e6_rise", rise, 4'b1111);
        chk("rel_e6_fall", fall, 4'b0000);
        chk("rel_e6_any", {3'b0, any_edge}, 4'b0001);
        step(1);
        chk("rel_e7_rise", rise, 4'b0000);
        chk("rel_e7_any", {3'b0, any_edge}, 4'b0000);
        chk("rel_e7_level", level, 4'b1111);

        // simultaneous fall on all channels
        in = 4'b0000;
        step(5);
        chk("simf_e5_level", level, 4'b1111);
        chk("simf_e5_fall", fall, 4'b0000);
        step(1);
        chk("simf_e6_level", level, 4'b0000);
        chk("simf_e6_fall", fall, 4'b1111);
        chk("simf_e6_rise", rise, 4'b0000);
        chk("simf_e6_any", {3'b0, any_edge}, 4'b0001);
        step(1);
        chk("simf_e7_fall", fall, 4'b0000);
        chk("simf_e7_any", {3'b0, any_edge}, 4'b0000);

        // clean rise on channel 0, then fall back
        in = 4'b0001;
        step(5);
        chk("rise0_e5_level", level, 4'b0000);
        chk("rise0_e5_rise", rise, 4'b0000);
        step(1);
        chk("rise0_e6_level", level, 4'b0001);
        chk("rise0_e6_rise", rise, 4'b0001);
        chk("rise0_e6_fall", fall, 4'b0000);
        step(1);
        chk("rise0_e7_rise", rise, 4'b0000);
        in = 4'b0000;
        step(5);
        chk("fall0_e5_fall", fall, 4'b0000);
        step(1);
        chk("fall0_e6_fall", fall, 4'b0001);
        chk("fall0_e6_level", level, 4'b0000);
        step(1);

        // 3-cycle glitch on channel 1 is rejected
        for (int k = 1; k <= 10; k++) begin
            in = (k <= 3) ? 4'b0010 : 4'b0000;
            step(1);
            chk($sformatf("glitch3_level_%0d", k), level, 4'b0000);
            chk($sformatf("glitch3_edges_%0d", k), rise | fall, 4'b0000);
        end

        // 4-cycle pulse on channel 1: one rise at edge 6, one fall at edge 10
        for (int k = 1; k <= 12; k++) begin
            in = (k <= 4) ? 4'b0010 : 4'b0000;
            step(1);
            chk($sformatf("pulse4_rise_%0d", k), rise, (k == 6) ? 4'b0010 : 4'b0000);
            chk($sformatf("pulse4_fall_%0d", k), fall, (k == 10) ? 4'b0010 : 4'b0000);
            chk($sformatf("pulse4_level_%0d", k), level, (k >= 6 && k < 10) ? 4'b0010 : 4'b0000);
        end

        // tick every 3rd cycle: s[2] changes after edge 2, ticks at 3,6,9,12 -> accept at 12
        for (int k = 1; k <= 14; k++) begin
            tick = (k % 3 == 0);
            in = 4'b0100;
            step(1);
            chk($sformatf("tick_level_%0d", k), level, (k >= 12) ? 4'b0100 : 4'b0000);
            chk($sformatf("tick_rise_%0d", k), rise, (k == 12) ? 4'b0100 : 4'b0000);
        end
        // short dip spanning one tick must not be accepted
        for (int k = 15; k <= 26; k++) begin
            tick = (k % 3 == 0);
            in = (k == 16 || k == 17) ? 4'b0000 : 4'b0100;
            step(1);
            chk($sformatf("tickdip_level_%0d", k), level, 4'b0100);
            chk($sformatf("tickdip_fall_%0d", k), fall, 4'b0000);
        end
        tick = 1'b1;
        in = 4'b0000;
        step(8);
        chk("final_level", level, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
